sd_sinc3_decim: RTL and testbench

- Sinc3 (3rd-order CIC) decimation filter that consumes the 1-bit bitstream of the sigma-delta modulator.
- Produces signed WIDTH-bit samples at clock/DECIM, each with a one-cycle valid strobe.
- Sits directly downstream of the modulator, on the same clock. It is the demodulator for both the loop-back testbench and the ADC capture path.

---
 rtl/sd_sinc3_decim.sv | 105 ++++++++++
 tb/tb_sd_sinc3_decim.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_sinc3_decim.sv
// Sinc3 (3rd-order CIC) decimator for a 1-bit sigma-delta bitstream.
// Optional input synchronizer enabled by defining SD_SINC3_SYNC_EN.
module sd_sinc3_decim #(
    parameter int DECIM = 256,
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    aclr,
    input  logic                    sdi,
    output logic signed [WIDTH-1:0] dout,
    output logic                    dvalid
);

    localparam int LG = $clog2(DECIM);
    localparam int AW = 3 * LG + 1;
    localparam int SH = 3 * LG - (WIDTH - 1);

    localparam logic [AW:0] FS = (AW + 1)'(1) << (3 * LG);
    localparam logic signed [AW:0] OMAX = $signed((AW + 1)'(2 ** (WIDTH - 1) - 1));
    localparam logic signed [AW:0] OMIN = ~OMAX;

    logic [AW-1:0] i1, i2, i3;
    logic [AW-1:0] d1, d2, d3;
    logic [AW-1:0] c1, c2, c3;
    logic [LG-1:0] cnt;
    logic [1:0]    warm;
    logic          tick;
    logic          bit_in;

    logic signed [AW:0]      s;
    logic signed [AW:0]      sh;
    logic signed [WIDTH-1:0] out;

`ifdef SD_SINC3_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sdi};
        end
    end

    assign bit_in = sync_q[1];
`else
    assign bit_in = sdi;
`endif

    assign tick = (cnt == LG'(DECIM - 1));

    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    // c3 spans 0..DECIM^3; map it onto a signed range centred on zero
    assign s  = $signed({c3, 1'b0} - FS);
    assign sh = s >>> SH;

    always_comb begin
        out = sh[WIDTH-1:0];
        if (sh > OMAX) begin
            out = OMAX[WIDTH-1:0];
        end else if (sh < OMIN) begin
            out = OMIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
            cnt <= '0;
        end else begin
            i1 <= i1 + {{(AW - 1){1'b0}}, bit_in};
            i2 <= i2 + i1;
            i3 <= i3 + i2;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            warm <= '0;
            dout <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= tick && warm[1];
            if (tick) begin
                d1 <= i3;
                d2 <= c1;
                d3 <= c2;
                dout <= out;
                if (warm != 2'd3) begin
                    warm <= warm + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_sinc3_decim.sv
// Self-checking bench for sd_sinc3_decim (DECIM=256, WIDTH=16).
// Tick-sampled running-sum model plus directed literal checks.
module tb_sd_sinc3_decim;

    localparam int DECIM = 256;
    localparam int WIDTH = 16;
    localparam int LG = 8;
    localparam int AW = 3 * LG + 1;
    localparam int SH = 3 * LG - (WIDTH - 1);
    localparam longint MASK = (longint'(1) << AW) - 1;
    localparam longint D3 = longint'(1) << (3 * LG);

    logic clock = 1'b0;
    logic aclr = 1'b1;
    logic sdi = 1'b0;
    logic signed [WIDTH-1:0] dout;
    logic dvalid;

    int total = 0;
    int bad = 0;

    int mode = 0;
    int plen = 1;
    int ph = 0;
    int acc = 0;
    int u = 0;
    bit pat [4] = '{default: 1'b0};

    sd_sinc3_decim #(.DECIM(DECIM), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .aclr  (aclr),
        .sdi   (sdi),
        .dout  (dout),
        .dvalid(dvalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic near(input string nm, input longint act, input longint exp,
                        input longint tol);
        total++;
        if (act > exp + tol || act < exp - tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
        end
    endtask

    // Bitstream source: fixed repeating pattern or first-order modulator
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (mode == 1) begin
                sdi = (acc >= 0);
                acc = acc + u - (sdi ? 32767 : -32767);
            end else begin
                sdi = pat[ph % plen];
                ph++;
            end
        end
    end

    // Model: sample the triple running sum at each tick, take its third
    // difference over the last four tick samples, then scale and clamp.
    initial begin : model
        longint s1, s2, s3, c3, sv, o;
        longint h [4];
        int n, tk;
        bit q1, q2, b, eff, ar, ev;
        longint ed;
        s1 = 0; s2 = 0; s3 = 0; n = 0; tk = 0; q1 = 0; q2 = 0;
        ev = 0; ed = 0;
        h = '{default: 0};
        forever begin
            @(posedge clock);
            b = sdi;
            ar = aclr;
            if (ar) begin
                s1 = 0; s2 = 0; s3 = 0; n = 0; tk = 0; q1 = 0; q2 = 0;
                ev = 0; ed = 0;
                h = '{default: 0};
            end else begin
                ev = 0;
                if (n % DECIM == DECIM - 1) begin
                    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s3;
                    c3 = (h[0] - 3 * h[1] + 3 * h[2] - h[3]) & MASK;
                    sv = 2 * c3 - D3;
                    o = sv >>> SH;
                    if (o > 32767) o = 32767;
                    if (o < -32768) o = -32768;
                    ed = o;
                    if (tk < 3) tk++;
                    ev = (tk >= 3);
                end
`ifdef SD_SINC3_SYNC_EN
                eff = q2; q2 = q1; q1 = b;
`else
                eff = b;
`endif
                s3 = (s3 + s2) & MASK;
                s2 = (s2 + s1) & MASK;
                s1 = (s1 + longint'(eff)) & MASK;
                n++;
            end
            @(negedge clock);
            if (!aclr) begin
                chk("model_dvalid", longint'(dvalid), longint'(ev));
                chk("model_dout", longint'(dout), ed);
            end
        end
    end

    task automatic set_pat(input bit a, input bit b2, input bit c, input bit d,
                           input int l);
        pat[0] = a; pat[1] = b2; pat[2] = c; pat[3] = d;
        plen = l;
        mode = 0;
    endtask

    task automatic restart();
        @(negedge clock);
        #1 aclr = 1'b1;
        ph = 0;
        acc = 0;
        @(negedge clock);
        #1;
        chk("rst_dout", longint'(dout), 0);
        chk("rst_dvalid", longint'(dvalid), 0);
        aclr = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!dvalid && c < 1000);
        if (!dvalid) chk("dvalid_timeout", longint'(dvalid), 1);
    endtask

    initial begin : stim
        int c;
        set_pat(0, 0, 0, 0, 1);
        restart();
        wait_valid(c);
        chk("first_latency", c, 768);
        chk("neg_fs", longint'(dout), -32768);
        repeat (2) begin
            wait_valid(c);
            chk("period", c, 256);
            chk("neg_fs", longint'(dout), -32768);
        end

        set_pat(1, 1, 1, 1, 1);
        restart();
        wait_valid(c);
        chk("first_latency_pos", c, 768);
        chk("pos_fs", longint'(dout), 32767);
        wait_valid(c);
        chk("period_pos", c, 256);
        chk("pos_fs", longint'(dout), 32767);

        #1 aclr = 1'b1;
        #1;
        chk("reset_drop_dvalid", longint'(dvalid), 0);
        chk("reset_drop_dout", longint'(dout), 0);
        @(negedge clock);
        #1 aclr = 1'b0;
        wait_valid(c);
        chk("relatency", c, 768);
        chk("pos_fs_after_rst", longint'(dout), 32767);

        set_pat(1, 0, 1, 0, 2);
        restart();
        wait_valid(c);
        repeat (2) begin
            wait_valid(c);
            near("alt_mid", longint'(dout), 0, 1);
        end

        set_pat(1, 1, 1, 0, 4);
        restart();
        wait_valid(c);
        repeat (2) begin
            wait_valid(c);
            near("three_quarter", longint'(dout), 16384, 1);
        end

        u = 8192;
        mode = 1;
        restart();
        repeat (4) begin
            wait_valid(c);
            near("loopback", longint'(dout), 8192, 64);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
